// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, single-cycle
// flush with redirect target, stall watchdog and stall-cycle statistics.
module pipeline_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00000020,
   parameter logic [31:0] ERET_CODE  = 32'h0000000e,
   parameter logic [7:0]  TIMEOUT    = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_total
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] new_pc_q, new_pc_d;
   // Set once an exception has been taken; a code still present afterwards
   // belongs to the same faulting instruction and must not flush again.
   logic        exc_block_q, exc_block_d;
   logic [7:0]  wdog_q, wdog_d;
   logic        timeout_q, timeout_d;
   logic [31:0] total_q, total_d;

   logic        stall_en;
   logic        exc_seen;

   // Requests only take effect while out of reset and not flushing.
   assign stall_en = rst && (state_q == ST_RUN);
   assign exc_seen = (excepttype != 32'h0);

   // A request from stage k holds that stage and every stage upstream of it;
   // the deepest requester therefore wins, giving mem > ex > id priority.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_stall
         localparam logic HELD_BY_MEM = (gi <= 4);
         localparam logic HELD_BY_EX  = (gi <= 3);
         localparam logic HELD_BY_ID  = (gi <= 2);
         assign stall[gi] = stall_en &&
                            ((HELD_BY_MEM && stallreq_mem) ||
                             (HELD_BY_EX  && stallreq_ex)  ||
                             (HELD_BY_ID  && stallreq_id));
      end
   endgenerate

   // FSM next state: take an exception in RUN, spend exactly one cycle in FLUSH.
   always_comb begin
      state_d     = state_q;
      new_pc_d    = new_pc_q;
      exc_block_d = exc_block_q;
      if (!exc_seen) begin
         exc_block_d = 1'b0;
      end
      case (state_q)
         ST_RUN: begin
            if (exc_seen && !exc_block_q) begin
               state_d     = ST_FLUSH;
               exc_block_d = 1'b1;
               new_pc_d    = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Watchdog and statistics next state, driven by the PC hold bit.
   always_comb begin
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      total_d   = total_q + {31'h0, stall[0]};
      if (!stall[0] || flush) begin
         wdog_d = 8'h0;
      end else if (wdog_q != TIMEOUT) begin
         wdog_d = wdog_q + 8'd1;
      end
      if (stall[0] && (wdog_d == TIMEOUT)) begin
         timeout_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         new_pc_q    <= 32'h0;
         exc_block_q <= 1'b0;
         wdog_q      <= 8'h0;
         timeout_q   <= 1'b0;
         total_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         new_pc_q    <= new_pc_d;
         exc_block_q <= exc_block_d;
         wdog_q      <= wdog_d;
         timeout_q   <= timeout_d;
         total_q     <= total_d;
      end
   end

   assign flush         = (state_q == ST_FLUSH);
   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;
   assign stall_total   = total_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall priority, exception flush/redirect,
// held exceptions, watchdog timeout and reset during flush.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_total;

   int checks = 0;
   int passed = 0;

   pipeline_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excepttype   (excepttype),
      .cp0_epc      (cp0_epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_timeout(stall_timeout),
      .stall_total  (stall_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
         $display("check %s: observed %h expected %h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
      excepttype = 32'h0; cp0_epc = 32'h0;
      tick(); tick();

      // Reset state; stall forced low while in reset even with a request.
      stallreq_mem = 1'b1; #1;
      check("rst_stall",   {26'h0, stall}, 32'h00);
      check("rst_flush",   {31'h0, flush}, 32'h0);
      check("rst_new_pc",  new_pc, 32'h0);
      check("rst_timeout", {31'h0, stall_timeout}, 32'h0);
      check("rst_total",   stall_total, 32'h0);
      stallreq_mem = 1'b0;
      rst = 1'b1;
      tick();
      check("rst_total_held", stall_total, 32'h0);

      // Stall priority, all combinational within one cycle.
      stallreq_ex = 1'b1; stallreq_id = 1'b1; #1;
      check("stall_ex_id", {26'h0, stall}, 32'h0F);
      stallreq_mem = 1'b1; #1;
      check("stall_mem_ex_id", {26'h0, stall}, 32'h1F);
      stallreq_mem = 1'b0; stallreq_ex = 1'b0; stallreq_id = 1'b0; #1;
      check("stall_release", {26'h0, stall}, 32'h00);
      stallreq_id = 1'b1; #1;
      check("stall_id", {26'h0, stall}, 32'h07);
      tick();
      check("total_one", stall_total, 32'h1);
      stallreq_id = 1'b0;
      tick();
      check("total_hold", stall_total, 32'h1);

      // General exception -> vector.
      excepttype = 32'h00000001;
      tick();
      check("exc_flush", {31'h0, flush}, 32'h1);
      check("exc_new_pc", new_pc, 32'h00000020);
      excepttype = 32'h0;
      tick();
      check("exc_flush_end", {31'h0, flush}, 32'h0);
      check("exc_new_pc_hold", new_pc, 32'h00000020);

      // ERET -> EPC.
      excepttype = 32'h0000000e; cp0_epc = 32'hBFC00100;
      tick();
      check("eret_flush", {31'h0, flush}, 32'h1);
      check("eret_new_pc", new_pc, 32'hBFC00100);
      excepttype = 32'h0; cp0_epc = 32'h0;
      tick();
      check("eret_flush_end", {31'h0, flush}, 32'h0);

      // Exception held 3 cycles with a concurrent mem stall.
      excepttype = 32'h00000005; stallreq_mem = 1'b1; #1;
      check("held_detect_stall", {26'h0, stall}, 32'h1F);
      tick();
      check("held_flush", {31'h0, flush}, 32'h1);
      check("held_flush_stall", {26'h0, stall}, 32'h00);
      tick();
      check("held_after1", {31'h0, flush}, 32'h0);
      tick();
      check("held_after2", {31'h0, flush}, 32'h0);
      check("held_total", stall_total, 32'h3);
      excepttype = 32'h0; stallreq_mem = 1'b0;
      tick();
      check("held_after3", {31'h0, flush}, 32'h0);

      // Watchdog: fresh reset, then 255 stalled cycles.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      stallreq_mem = 1'b1;
      for (int i = 0; i < 254; i++) tick();
      check("wdog_254_timeout", {31'h0, stall_timeout}, 32'h0);
      tick();
      check("wdog_255_timeout", {31'h0, stall_timeout}, 32'h1);
      check("wdog_255_total", stall_total, 32'd255);
      stallreq_mem = 1'b0;
      tick();
      check("wdog_sticky", {31'h0, stall_timeout}, 32'h1);
      check("wdog_total_hold", stall_total, 32'd255);

      // Reset during the flush cycle aborts it.
      excepttype = 32'h00000001;
      tick();
      check("rflush_flush", {31'h0, flush}, 32'h1);
      rst = 1'b0; excepttype = 32'h0;
      tick();
      check("rflush_flush_clr", {31'h0, flush}, 32'h0);
      check("rflush_new_pc", new_pc, 32'h0);
      check("rflush_total", stall_total, 32'h0);
      check("rflush_timeout", {31'h0, stall_timeout}, 32'h0);
      rst = 1'b1; excepttype = 32'h00000003;
      tick();
      check("post_reset_exc", {31'h0, flush}, 32'h1);
      excepttype = 32'h0;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000020, exception entry address.
REQ-002 SHALL have parameter ERET_CODE, default 32'h0000000e, excepttype value meaning return-from-exception.
REQ-003 SHALL have parameter TIMEOUT, default 8'd255, consecutive stall cycles before the watchdog fires.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-006 SHALL have port stallreq_id  input  1  ID-stage stall request.
REQ-007 SHALL have port stallreq_ex  input  1  EX-stage stall request (multi-cycle op).
REQ-008 SHALL have port stallreq_mem  input  1  MEM-stage stall request (bus wait).
REQ-009 SHALL have port excepttype  input  32  MEM-stage exception code; 0 = none.
REQ-010 SHALL have port cp0_epc  input  32  EPC value for the ERET target.
REQ-011 SHALL have port stall  output  6  per-stage hold; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-012 SHALL have port flush  output  1  pipeline flush pulse, registered.
REQ-013 SHALL have port new_pc  output  32  redirect target, valid while flush=1, registered.
REQ-014 SHALL have port stall_timeout  output  1  sticky watchdog flag, registered.
REQ-015 SHALL have port stall_total  output  32  count of cycles with stall[0]=1, registered.

Function
REQ-016 SHALL implement FSM with states RUN and FLUSH.
REQ-017 In RUN, stall SHALL be combinational from requests with priority: stallreq_mem -> 6'b011111, else stallreq_ex -> 6'b001111, else stallreq_id -> 6'b000111, else 6'b000000.
REQ-018 In FLUSH, stall SHALL be 6'b000000 regardless of requests.
REQ-019 In RUN with excepttype != 0 at a posedge, the FSM SHALL move to FLUSH, and flush SHALL be 1 in the following cycle.
REQ-020 An exception SHALL take priority over any concurrent stall request; stall still follows REQ-017 in the detection cycle.
REQ-021 new_pc SHALL be loaded with cp0_epc if excepttype == ERET_CODE, else EXC_VECTOR, on the same edge that sets flush.
REQ-022 FLUSH SHALL last exactly one cycle, then the FSM SHALL return to RUN; flush SHALL deassert.
REQ-023 excepttype SHALL be ignored while in FLUSH, so back-to-back exceptions give a single flush pulse.
REQ-024 new_pc SHALL hold its last value when flush=0.
REQ-025 Watchdog counter (8 bits) SHALL increment each cycle stall[0]=1 and clear when stall[0]=0 or flush=1.
REQ-026 The watchdog counter SHALL saturate at TIMEOUT; stall_timeout SHALL set on the edge where the counter reaches TIMEOUT and stay 1 until reset.
REQ-027 stall_total SHALL increment on each cycle with stall[0]=1 and wrap from 32'hFFFFFFFF to 0.

Reset
REQ-028 With rst=0 at a posedge, the block SHALL enter RUN with flush=0, new_pc=32'h0, stall_timeout=0, stall_total=0 and watchdog=0.
REQ-029 While rst=0, stall SHALL be 6'b000000.
REQ-030 A reset during FLUSH SHALL abort the flush, with flush=0 from the next cycle.

Verification
REQ-031 Raise stallreq_ex=1 and stallreq_id=1 together -> stall=6'b001111; add stallreq_mem=1 -> 6'b011111; release all -> 6'b000000 in the same cycle.
REQ-032 Pulse excepttype=32'h00000001 for one cycle -> next cycle flush=1 and new_pc=32'h00000020; flush=0 the cycle after.
REQ-033 excepttype=32'h0000000e with cp0_epc=32'hBFC00100 -> flush=1 and new_pc=32'hBFC00100 one cycle later.
REQ-034 Hold excepttype nonzero for 3 cycles -> exactly one flush cycle, with stall=0 during it even if stallreq_mem=1.
REQ-035 Hold stallreq_mem=1 for 255 cycles -> stall_timeout=1 after cycle 255 and stays 1 after the request drops; stall_total=255.
REQ-036 Assert rst=0 in the flush cycle -> flush=0, new_pc=0 and stall_total=0 in the next cycle.
